bsg_manycore_io_sdr_reset_sequencer: RTL and testbench
======================================================

// Module: bsg_manycore_io_sdr_reset_sequencer
// PURPOSE
//  Drives the four async reset lines of a chain of SDR I/O router links in the bsg_link bring-up order.
//  Order: hold all link resets, pulse token reset, release uplink, release downlink, release downstream.
//  Sits on the core clock domain at the head of the I/O router column. Its outputs feed async_*_reset_i
//  of the first link, which forwards them down the chain. Re-runs on request, for link retraining.
// PARAMETERS
//  init_cycles_p    16  cycles all resets held asserted after reset_i/start_i (>=1)
//  token_cycles_p    8  width of async_token_reset_o pulse in core cycles (>=1)
//  settle_cycles_p  32  wait after each token/reset edge before next step (>=1)
//  cnt_width_lp  derived  $clog2(max(init,token,settle)+1)
// PORTS
//  core_clk_i                in   1  core clock
//  core_reset_i              in   1  synchronous active-high reset
//  start_i                   in   1  restart request; honoured only in DONE
//  async_uplink_reset_o      out  1  to link uplink reset (registered)
//  async_downlink_reset_o    out  1  to link downlink reset (registered)
//  async_downstream_reset_o  out  1  to link downstream reset (registered)
//  async_token_reset_o       out  1  to link token reset (registered)
//  busy_o                    out  1  sequence in progress (state != DONE)
//  done_o                    out  1  links out of reset, traffic may flow
// BEHAVIOUR
//  - One clock, core_clk_i. core_reset_i is synchronous and active-high.
//  - On core_reset_i: state=INIT, cnt=init_cycles_p-1. Outputs: uplink=1, downlink=1, downstream=1,
//    token=0, busy=1, done=0.
//  - All outputs are flops loaded from the next-state decode, so every output equals a function of the current state.
//  - Down-counter: loaded with N-1 on entry to a state of length N. Decrements each cycle.
//    The state advances on the cycle cnt==0, so each state lasts exactly N cycles.
//  - States, lengths and outputs (up/dn/ds/tok):
//      INIT      init_cycles_p    1/1/1/0
//      TOK_HI    token_cycles_p   1/1/1/1
//      TOK_LO    settle_cycles_p  1/1/1/0
//      UP_REL    settle_cycles_p  0/1/1/0
//      DN_REL    settle_cycles_p  0/0/1/0
//      DS_REL    settle_cycles_p  0/0/0/0
//      DONE      unbounded        0/0/0/0, done=1, busy=0
//  - The sequence is INIT->TOK_HI->TOK_LO->UP_REL->DN_REL->DS_REL->DONE. No other transitions.
//  - DONE + start_i: next state is INIT, cnt=init_cycles_p-1.
//    All three resets re-assert on the next cycle, and done drops the same cycle.
//  - start_i outside DONE is ignored. A sequence in flight is never restarted or shortened.
//  - core_reset_i together with start_i: reset wins, with identical result.
//  - core_reset_i mid-sequence: abort and return to INIT. If token was high it drops the next cycle;
//    it is never stretched.
//  - Latency from the first cycle out of reset to done_o=1 is I+T+4S cycles (defaults: 152).
//  - Monotonic invariants:
//      a reset line, once released, stays low until INIT;
//      token is never high while uplink reset is low;
//      release order up -> dn -> ds is always kept.
//  - Counter width is never exceeded: load values are <= max param - 1. The counter has no wrap-around.
// STRUCTURE
//  - State enum bsg_manycore_io_sdr_rst_state_e (3 bits) lives in the shared bsg_manycore_io_sdr_pkg,
//    so the testbench and top level can monitor it.
//  - One sub-module: bsg_manycore_io_sdr_rst_cnt, a loadable down-counter with zero_o.
//    Rest is a single FSM always_ff block plus the output flops.
//  - Elaboration-time asserts: each *_cycles_p >= 1.
// TESTING
//  1. Defaults, core_reset_i high 4 cycles then low:
//     tok=1 in cycles 16..23, up=0 at 56, dn=0 at 88, ds=0 at 120, done=1 at 152, busy=0 at 152.
//  2. start_i pulse at cycle 200 (in DONE):
//     up/dn/ds=1 and done=0 at 201, tok=1 at 217..224, done=1 at 353.
//  3. start_i held high from cycle 30 to 100:
//     no effect on timing, done at 152. If still high in DONE, the sequence re-enters INIT.
//  4. core_reset_i asserted at cycle 20 (during TOK_HI):
//     tok=0 at 21, all resets=1, and the sequence restarts from INIT after reset drops.
//  5. init=1, token=1, settle=1:
//     INIT 1 cycle, tok high exactly 1 cycle, done=1 at cycle 6.
//  6. Random start_i and core_reset_i for 10k cycles with a bsg_link_sdr pair attached:
//     invariants hold (order, no token while up=0), and packets pass after each done_o.

Source files
------------

// File: rtl/bsg_manycore_io_sdr_pkg.sv
// Shared types for the SDR I/O link reset sequencer: state encoding and output bundle.
package bsg_manycore_io_sdr_pkg;

  typedef enum logic [2:0] {
    RST_INIT   = 3'd0,
    RST_TOK_HI = 3'd1,
    RST_TOK_LO = 3'd2,
    RST_UP_REL = 3'd3,
    RST_DN_REL = 3'd4,
    RST_DS_REL = 3'd5,
    RST_DONE   = 3'd6
  } bsg_manycore_io_sdr_rst_state_e;

  typedef struct packed {
    logic uplink;
    logic downlink;
    logic downstream;
    logic token;
    logic busy;
    logic done;
  } bsg_manycore_io_sdr_rst_out_s;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Link reset levels for each step of the bring-up order.
  function automatic bsg_manycore_io_sdr_rst_out_s rst_decode(
      input bsg_manycore_io_sdr_rst_state_e s);
    bsg_manycore_io_sdr_rst_out_s o;
    o = '{uplink: 1'b1, downlink: 1'b1, downstream: 1'b1, token: 1'b0, busy: 1'b1, done: 1'b0};
    case (s)
      RST_TOK_HI: o.token = 1'b1;
      RST_UP_REL: o.uplink = 1'b0;
      RST_DN_REL: begin
        o.uplink   = 1'b0;
        o.downlink = 1'b0;
      end
      RST_DS_REL: begin
        o.uplink     = 1'b0;
        o.downlink   = 1'b0;
        o.downstream = 1'b0;
      end
      RST_DONE: begin
        o.uplink     = 1'b0;
        o.downlink   = 1'b0;
        o.downstream = 1'b0;
        o.busy       = 1'b0;
        o.done       = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/bsg_manycore_io_sdr_rst_cnt.sv
// Loadable down-counter that holds at zero; zero_o flags the last cycle of a step.
module bsg_manycore_io_sdr_rst_cnt #(
  parameter int unsigned width_p = 6
) (
  input  logic               clk_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  output logic               zero_o
);

  logic [width_p-1:0] cnt_r;

  always_ff @(posedge clk_i) begin
    if (load_i)
      cnt_r <= load_val_i;
    else if (cnt_r != '0)
      cnt_r <= cnt_r - width_p'(1);
  end

  assign zero_o = (cnt_r == '0);

endmodule

// File: rtl/bsg_manycore_io_sdr_reset_sequencer.sv
// Sequences the async reset lines of an SDR I/O link chain in bsg_link bring-up order;
// restartable from DONE for link retraining.
module bsg_manycore_io_sdr_reset_sequencer
  import bsg_manycore_io_sdr_pkg::*;
#(
  parameter int unsigned init_cycles_p   = 16,
  parameter int unsigned token_cycles_p  = 8,
  parameter int unsigned settle_cycles_p = 32
) (
  input  logic core_clk_i,
  input  logic core_reset_i,
  input  logic start_i,
  output logic async_uplink_reset_o,
  output logic async_downlink_reset_o,
  output logic async_downstream_reset_o,
  output logic async_token_reset_o,
  output logic busy_o,
  output logic done_o
);

  localparam int unsigned max_cycles_lp = max3(init_cycles_p, token_cycles_p, settle_cycles_p);
  localparam int unsigned cnt_width_lp  = $clog2(max_cycles_lp + 1);

  if (init_cycles_p < 1) begin : g_bad_init
    $error("init_cycles_p must be >= 1");
  end
  if (token_cycles_p < 1) begin : g_bad_token
    $error("token_cycles_p must be >= 1");
  end
  if (settle_cycles_p < 1) begin : g_bad_settle
    $error("settle_cycles_p must be >= 1");
  end

  bsg_manycore_io_sdr_rst_state_e state_r, state_n;
  bsg_manycore_io_sdr_rst_out_s   out_r;
  logic                           cnt_zero;
  logic                           load_c;
  logic [cnt_width_lp-1:0]        load_val_c;

  bsg_manycore_io_sdr_rst_cnt #(
    .width_p(cnt_width_lp)
  ) cnt (
    .clk_i     (core_clk_i),
    .load_i    (load_c),
    .load_val_i(load_val_c),
    .zero_o    (cnt_zero)
  );

  // Next-state and counter reload; the counter is reloaded on every state entry.
  always_comb begin
    state_n    = state_r;
    load_c     = 1'b0;
    load_val_c = '0;
    case (state_r)
      RST_INIT:   if (cnt_zero) state_n = RST_TOK_HI;
      RST_TOK_HI: if (cnt_zero) state_n = RST_TOK_LO;
      RST_TOK_LO: if (cnt_zero) state_n = RST_UP_REL;
      RST_UP_REL: if (cnt_zero) state_n = RST_DN_REL;
      RST_DN_REL: if (cnt_zero) state_n = RST_DS_REL;
      RST_DS_REL: if (cnt_zero) state_n = RST_DONE;
      RST_DONE:   if (start_i)  state_n = RST_INIT;
      default:                  state_n = RST_INIT;
    endcase
    if (core_reset_i)
      state_n = RST_INIT;
    load_c = core_reset_i || (state_n != state_r);
    case (state_n)
      RST_INIT:   load_val_c = cnt_width_lp'(init_cycles_p - 1);
      RST_TOK_HI: load_val_c = cnt_width_lp'(token_cycles_p - 1);
      RST_TOK_LO,
      RST_UP_REL,
      RST_DN_REL,
      RST_DS_REL: load_val_c = cnt_width_lp'(settle_cycles_p - 1);
      default:    load_val_c = '0;
    endcase
  end

  // State and output flops; outputs are decoded from the state being entered.
  always_ff @(posedge core_clk_i) begin
    if (core_reset_i) begin
      state_r <= RST_INIT;
      out_r   <= rst_decode(RST_INIT);
    end else begin
      state_r <= state_n;
      out_r   <= rst_decode(state_n);
    end
  end

  assign async_uplink_reset_o     = out_r.uplink;
  assign async_downlink_reset_o   = out_r.downlink;
  assign async_downstream_reset_o = out_r.downstream;
  assign async_token_reset_o      = out_r.token;
  assign busy_o                   = out_r.busy;
  assign done_o                   = out_r.done;

endmodule

// File: tb/tb_bsg_manycore_io_sdr_reset_sequencer.sv
// Directed and random checks of the SDR link reset sequencer (default and minimum timings).
module tb_bsg_manycore_io_sdr_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, up, dn, ds, tok, busy, done;
  logic rst1, start1, up1, dn1, ds1, tok1, busy1, done1;
  logic [5:0] obs, obs1;

  assign obs  = {up, dn, ds, tok, busy, done};
  assign obs1 = {up1, dn1, ds1, tok1, busy1, done1};

  int checks = 0;
  int errors = 0;

  bsg_manycore_io_sdr_reset_sequencer dut (
    .core_clk_i              (clk),
    .core_reset_i            (rst),
    .start_i                 (start),
    .async_uplink_reset_o    (up),
    .async_downlink_reset_o  (dn),
    .async_downstream_reset_o(ds),
    .async_token_reset_o     (tok),
    .busy_o                  (busy),
    .done_o                  (done)
  );

  bsg_manycore_io_sdr_reset_sequencer #(
    .init_cycles_p  (1),
    .token_cycles_p (1),
    .settle_cycles_p(1)
  ) dut1 (
    .core_clk_i              (clk),
    .core_reset_i            (rst1),
    .start_i                 (start1),
    .async_uplink_reset_o    (up1),
    .async_downlink_reset_o  (dn1),
    .async_downstream_reset_o(ds1),
    .async_token_reset_o     (tok1),
    .busy_o                  (busy1),
    .done_o                  (done1)
  );

  // Expected {up,dn,ds,tok,busy,done} t cycles after entering INIT.
  function automatic logic [5:0] model(input int t, input int i, input int k, input int s);
    if (t < i)               return 6'b111010;
    if (t < i + k)           return 6'b111110;
    if (t < i + k + s)       return 6'b111010;
    if (t < i + k + 2 * s)   return 6'b011010;
    if (t < i + k + 3 * s)   return 6'b001010;
    if (t < i + k + 4 * s)   return 6'b000010;
    return 6'b000001;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (4) step();
    checks++;
    if (obs !== 6'b111010) begin
      errors++;
      $display("FAIL reset_state got %b want %b", obs, 6'b111010);
    end
    rst = 1'b0;
  endtask

  task automatic test_sequence();
    for (int t = 0; t < 200; t++) begin
      checks++;
      if (obs !== model(t, 16, 8, 32)) begin
        errors++;
        $display("FAIL sequence t=%0d got %b want %b", t, obs, model(t, 16, 8, 32));
      end
      step();
    end
  endtask

  task automatic test_restart();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 0; t <= 160; t++) begin
      checks++;
      if (obs !== model(t, 16, 8, 32)) begin
        errors++;
        $display("FAIL restart t=%0d got %b want %b", t, obs, model(t, 16, 8, 32));
      end
      step();
    end
  endtask

  task automatic test_start_held();
    test_reset();
    for (int t = 0; t < 152; t++) begin
      start = (t >= 30 && t <= 100);
      checks++;
      if (obs !== model(t, 16, 8, 32)) begin
        errors++;
        $display("FAIL start_held t=%0d got %b want %b", t, obs, model(t, 16, 8, 32));
      end
      step();
    end
    checks++;
    if (obs !== 6'b000001) begin
      errors++;
      $display("FAIL start_held_done got %b want %b", obs, 6'b000001);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (obs !== 6'b111010) begin
      errors++;
      $display("FAIL start_held_reenter got %b want %b", obs, 6'b111010);
    end
  endtask

  task automatic test_reset_mid();
    test_reset();
    for (int t = 0; t <= 20; t++) begin
      checks++;
      if (obs !== model(t, 16, 8, 32)) begin
        errors++;
        $display("FAIL mid_pre t=%0d got %b want %b", t, obs, model(t, 16, 8, 32));
      end
      if (t < 20) step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (obs !== 6'b111010) begin
      errors++;
      $display("FAIL mid_abort got %b want %b", obs, 6'b111010);
    end
    for (int t = 0; t <= 152; t++) begin
      checks++;
      if (obs !== model(t, 16, 8, 32)) begin
        errors++;
        $display("FAIL mid_rerun t=%0d got %b want %b", t, obs, model(t, 16, 8, 32));
      end
      step();
    end
  endtask

  task automatic test_min_params();
    rst1 = 1'b1; start1 = 1'b0;
    repeat (2) step();
    rst1 = 1'b0;
    for (int t = 0; t < 10; t++) begin
      checks++;
      if (obs1 !== model(t, 1, 1, 1)) begin
        errors++;
        $display("FAIL min t=%0d got %b want %b", t, obs1, model(t, 1, 1, 1));
      end
      step();
    end
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int t = 0; t < 8; t++) begin
      checks++;
      if (obs1 !== model(t, 1, 1, 1)) begin
        errors++;
        $display("FAIL min_restart t=%0d got %b want %b", t, obs1, model(t, 1, 1, 1));
      end
      step();
    end
  endtask

  task automatic test_random();
    int t, tn;
    test_reset();
    t = 0;
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 7) == 0);
      checks++;
      if (obs !== model(t, 16, 8, 32)) begin
        errors++;
        $display("FAIL random c=%0d t=%0d got %b want %b", c, t, obs, model(t, 16, 8, 32));
      end
      checks++;
      if ((tok && !up) || (!dn && up) || (!ds && dn) || (done === busy)) begin
        errors++;
        $display("FAIL invariant c=%0d got %b want ordered", c, obs);
      end
      if (rst)
        tn = 0;
      else if (model(t, 16, 8, 32) == 6'b000001 && start)
        tn = 0;
      else
        tn = (t < 1000) ? t + 1 : t;
      step();
      t = tn;
    end
    rst = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rst1 = 1'b1; start1 = 1'b0;
    test_reset();
    test_sequence();
    test_restart();
    test_start_held();
    test_reset_mid();
    test_min_params();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
